// File: rtl/i2c_mst_byte_seq.sv
// Byte-level I2C master sequencer.
// Walks 10-bit TX FIFO entries ([9]=STOP after, [8]=START before, [7:0]=byte)
// and issues START/WRITE/READ/STOP commands to the bit controller. Read bursts
// take their byte count from the entry that follows a read address.
module i2c_mst_byte_seq #(
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_cr_en,
    input  logic       i_tx_fifo_empty,
    input  logic [9:0] i_tx_fifo_dout,
    output logic       o_tx_fifo_rd,
    input  logic       i_rx_fifo_full,
    output logic       o_rx_fifo_wr,
    output logic [7:0] o_rx_fifo_din,
    output logic       o_cmd_valid,
    output logic [2:0] o_cmd_code,
    output logic [7:0] o_cmd_txd,
    output logic       o_cmd_nack,
    input  logic       i_cmd_done,
    input  logic [7:0] i_cmd_rxd,
    input  logic       i_cmd_rx_ack,
    input  logic       i_arb_lost,
    output logic       o_busy,
    output logic       o_nack_err,
    output logic       o_arb_err,
    output logic       o_seq_err
);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StWrite,
        StHold,
        StRcnt,
        StRead,
        StStop
    } state_e;

    state_e           r_state;
    logic             r_cmd_valid;
    logic [2:0]       r_cmd_code;
    logic [7:0]       r_cmd_txd;
    logic             r_cmd_nack;
    logic [7:0]       r_cur_byte;
    logic             r_cur_stop;
    logic             r_cur_rd;
    logic [CNT_W-1:0] r_rcnt;
    logic             r_rd_stop;
    logic             r_rx_wr;
    logic [7:0]       r_rx_din;
    logic             r_nack_err;
    logic             r_arb_err;
    logic             r_seq_err;

    logic             w_pop;
    logic             w_done;
    logic             w_last_rd;
    logic             w_cnt_zero;

    // Pop is combinational so the head entry is consumed in the decision cycle.
    assign w_pop = (((r_state == StIdle) || (r_state == StHold)) && i_cr_en && !i_tx_fifo_empty)
                   || ((r_state == StRcnt) && !i_tx_fifo_empty);
    // A completion pulse only counts while a command is actually outstanding.
    assign w_done     = i_cmd_done && r_cmd_valid;
    assign w_last_rd  = (r_rcnt == CNT_W'(1));
    assign w_cnt_zero = (i_tx_fifo_dout[CNT_W-1:0] == '0);

    // Sequencer FSM with registered command, RX push and error pulse outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= CMD_NOP;
            r_cmd_txd   <= 8'h00;
            r_cmd_nack  <= 1'b0;
            r_cur_byte  <= 8'h00;
            r_cur_stop  <= 1'b0;
            r_cur_rd    <= 1'b0;
            r_rcnt      <= '0;
            r_rd_stop   <= 1'b0;
            r_rx_wr     <= 1'b0;
            r_rx_din    <= 8'h00;
            r_nack_err  <= 1'b0;
            r_arb_err   <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_rx_wr    <= 1'b0;
            r_nack_err <= 1'b0;
            r_arb_err  <= 1'b0;
            r_seq_err  <= 1'b0;
            // Lost arbitration abandons the bus: no STOP, any completion is dropped.
            if ((r_state != StIdle) && i_arb_lost) begin
                r_state     <= StIdle;
                r_cmd_valid <= 1'b0;
                r_cmd_code  <= CMD_NOP;
                r_cmd_nack  <= 1'b0;
                r_arb_err   <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_pop) begin
                            r_cur_byte <= i_tx_fifo_dout[7:0];
                            r_cur_stop <= i_tx_fifo_dout[9];
                            r_cur_rd   <= i_tx_fifo_dout[0];
                            if (i_tx_fifo_dout[8]) begin
                                r_state     <= StStart;
                                r_cmd_valid <= 1'b1;
                                r_cmd_code  <= CMD_START;
                                r_cmd_nack  <= 1'b0;
                            end else begin
                                // Data without a preceding START has no bus to go to.
                                r_seq_err <= 1'b1;
                            end
                        end
                    end
                    StStart: begin
                        if (w_done) begin
                            r_state    <= StAddr;
                            r_cmd_code <= CMD_WRITE;
                            r_cmd_txd  <= r_cur_byte;
                        end
                    end
                    StAddr, StWrite: begin
                        if (w_done) begin
                            if (i_cmd_rx_ack) begin
                                // Leftover entries stay queued for software to flush.
                                r_nack_err <= 1'b1;
                                r_state    <= StStop;
                                r_cmd_code <= CMD_STOP;
                            end else if ((r_state == StAddr) && r_cur_rd) begin
                                r_state     <= StRcnt;
                                r_cmd_valid <= 1'b0;
                                r_cmd_code  <= CMD_NOP;
                            end else if (r_cur_stop) begin
                                r_state    <= StStop;
                                r_cmd_code <= CMD_STOP;
                            end else begin
                                r_state     <= StHold;
                                r_cmd_valid <= 1'b0;
                                r_cmd_code  <= CMD_NOP;
                            end
                        end
                    end
                    StHold: begin
                        if (!i_cr_en) begin
                            r_state     <= StStop;
                            r_cmd_valid <= 1'b1;
                            r_cmd_code  <= CMD_STOP;
                        end else if (w_pop) begin
                            r_cur_byte  <= i_tx_fifo_dout[7:0];
                            r_cur_stop  <= i_tx_fifo_dout[9];
                            r_cur_rd    <= i_tx_fifo_dout[0];
                            r_cmd_valid <= 1'b1;
                            if (i_tx_fifo_dout[8]) begin
                                r_state    <= StStart;
                                r_cmd_code <= CMD_START;
                            end else begin
                                r_state    <= StWrite;
                                r_cmd_code <= CMD_WRITE;
                                r_cmd_txd  <= i_tx_fifo_dout[7:0];
                            end
                        end
                    end
                    StRcnt: begin
                        if (w_pop) begin
                            r_rcnt    <= i_tx_fifo_dout[CNT_W-1:0];
                            r_rd_stop <= i_tx_fifo_dout[9];
                            if (!w_cnt_zero) begin
                                r_state <= StRead;
                            end else if (i_tx_fifo_dout[9]) begin
                                r_state     <= StStop;
                                r_cmd_valid <= 1'b1;
                                r_cmd_code  <= CMD_STOP;
                            end else begin
                                r_state <= StHold;
                            end
                        end
                    end
                    StRead: begin
                        if (!r_cmd_valid) begin
                            // Only ask for a byte when the RX FIFO can take it.
                            if (!i_rx_fifo_full) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_code  <= CMD_READ;
                                r_cmd_nack  <= w_last_rd;
                            end
                        end else if (w_done) begin
                            r_rx_wr     <= 1'b1;
                            r_rx_din    <= i_cmd_rxd;
                            r_cmd_nack  <= 1'b0;
                            if (r_rcnt != '0) begin
                                r_rcnt <= r_rcnt - CNT_W'(1);
                            end
                            if (w_last_rd && r_rd_stop) begin
                                r_state    <= StStop;
                                r_cmd_code <= CMD_STOP;
                            end else begin
                                r_cmd_valid <= 1'b0;
                                r_cmd_code  <= CMD_NOP;
                                if (w_last_rd) begin
                                    r_state <= StHold;
                                end
                            end
                        end
                    end
                    StStop: begin
                        if (w_done) begin
                            r_state     <= StIdle;
                            r_cmd_valid <= 1'b0;
                            r_cmd_code  <= CMD_NOP;
                        end
                    end
                    default: begin
                        r_state     <= StIdle;
                        r_cmd_valid <= 1'b0;
                        r_cmd_code  <= CMD_NOP;
                    end
                endcase
            end
        end
    end

    assign o_tx_fifo_rd  = w_pop;
    assign o_rx_fifo_wr  = r_rx_wr;
    assign o_rx_fifo_din = r_rx_din;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_code    = r_cmd_code;
    assign o_cmd_txd     = r_cmd_txd;
    assign o_cmd_nack    = r_cmd_nack;
    assign o_busy        = (r_state != StIdle);
    assign o_nack_err    = r_nack_err;
    assign o_arb_err     = r_arb_err;
    assign o_seq_err     = r_seq_err;

endmodule

// File: tb/tb_i2c_mst_byte_seq.sv
// Bench for i2c_mst_byte_seq: queue-based TX FIFO, responding bit-controller
// model, and a scoreboard fed by a transaction-level reference model.
module tb_i2c_mst_byte_seq;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_START = 3'd1;
    localparam logic [2:0] C_WRITE = 3'd2;
    localparam logic [2:0] C_READ  = 3'd3;
    localparam logic [2:0] C_STOP  = 3'd4;

    typedef struct {
        logic [2:0] code;
        logic [7:0] txd;
        logic       nack;
    } cmd_t;

    typedef struct {
        logic       ack;
        logic [7:0] rxd;
        logic       arb;
    } resp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cr_en = 1'b0;
    logic       tx_empty;
    logic [9:0] tx_dout;
    logic       tx_rd;
    logic       rx_full = 1'b0;
    logic       rx_wr;
    logic [7:0] rx_din;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [7:0] cmd_txd;
    logic       cmd_nack;
    logic       cmd_done;
    logic [7:0] cmd_rxd;
    logic       cmd_rx_ack;
    logic       arb_lost;
    logic       busy;
    logic       nack_err;
    logic       arb_err;
    logic       seq_err;

    cmd_t       exp_q[$];
    cmd_t       obs_q[$];
    resp_t      resp_q[$];
    logic [7:0] exp_rx[$];
    logic [9:0] txq[$];

    int n_vec = 0;
    int n_err = 0;
    int cnt_nack = 0;
    int cnt_arb = 0;
    int cnt_seq = 0;
    int n_read_obs = 0;
    int min_dly = 0;
    logic pop_pend = 1'b0;
    logic full_at_edge = 1'b0;

    i2c_mst_byte_seq #(.CNT_W(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_cr_en        (cr_en),
        .i_tx_fifo_empty(tx_empty),
        .i_tx_fifo_dout (tx_dout),
        .o_tx_fifo_rd   (tx_rd),
        .i_rx_fifo_full (rx_full),
        .o_rx_fifo_wr   (rx_wr),
        .o_rx_fifo_din  (rx_din),
        .o_cmd_valid    (cmd_valid),
        .o_cmd_code     (cmd_code),
        .o_cmd_txd      (cmd_txd),
        .o_cmd_nack     (cmd_nack),
        .i_cmd_done     (cmd_done),
        .i_cmd_rxd      (cmd_rxd),
        .i_cmd_rx_ack   (cmd_rx_ack),
        .i_arb_lost     (arb_lost),
        .o_busy         (busy),
        .o_nack_err     (nack_err),
        .o_arb_err      (arb_err),
        .o_seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: one expected command plus the response the bus will give it.
    task automatic expect_cmd(input logic [2:0] code, input logic [7:0] txd, input logic nack,
                              input logic ack, input logic [7:0] rxd, input logic arb);
        cmd_t  c;
        resp_t r;
        c.code = code;
        c.txd  = txd;
        c.nack = nack;
        r.ack  = ack;
        r.rxd  = rxd;
        r.arb  = arb;
        exp_q.push_back(c);
        resp_q.push_back(r);
        if (code == C_READ && !arb) exp_rx.push_back(rxd);
    endtask

    // One I2C transfer described at transaction level: address, byte count, stop.
    task automatic add_xfer(input logic [7:0] addr, input int n, input bit stop);
        logic [7:0] d;
        logic [9:0] cnt_entry;
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, addr, 1'b0, 1'b0, 8'h00, 1'b0);
        if (!addr[0]) begin
            txq.push_back({stop && (n == 0), 1'b1, addr});
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom());
                txq.push_back({stop && (i == n - 1), 1'b0, d});
                expect_cmd(C_WRITE, d, 1'b0, 1'b0, 8'h00, 1'b0);
            end
        end else begin
            txq.push_back({1'b0, 1'b1, addr});
            cnt_entry = 10'(n);
            cnt_entry[9] = stop;
            txq.push_back(cnt_entry);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom());
                expect_cmd(C_READ, 8'h00, (i == n - 1), 1'b0, d, 1'b0);
            end
        end
        if (stop) expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Runs until all expected traffic is seen and the block is idle, within a cycle budget.
    task automatic run_until_idle(input int lim, input bit drop_cr, input bit rand_full);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            step();
            if (rand_full) rx_full = ($urandom_range(0, 3) == 0);
            if (drop_cr && txq.size() == 0 && exp_q.size() <= 1) cr_en = 1'b0;
            if (exp_q.size() == 0 && exp_rx.size() == 0 && txq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        rx_full = 1'b0;
        cr_en   = 1'b1;
        chk("idle_reached", 32'(ok), 32'd1);
        chk("exp_cmds_left", exp_q.size(), 0);
    endtask

    // TX FIFO model: first-word-fall-through, pop decided by the pre-edge rd strobe.
    initial begin
        tx_empty = 1'b1;
        tx_dout  = 10'h000;
        forever begin
            @(negedge clk);
            pop_pend = tx_rd;
            @(posedge clk);
            #1;
            if (pop_pend && txq.size() != 0) void'(txq.pop_front());
            tx_empty = (txq.size() == 0);
            tx_dout  = tx_empty ? 10'h000 : txq[0];
        end
    end

    always @(posedge clk) full_at_edge = rx_full;

    // Bit-controller model: accepts a command, waits, then completes it.
    initial begin
        cmd_t  c;
        resp_t r;
        int    d;
        cmd_done   = 1'b0;
        arb_lost   = 1'b0;
        cmd_rx_ack = 1'b0;
        cmd_rxd    = 8'h00;
        @(negedge clk);
        forever begin
            if (rstn && cmd_valid) begin
                c.code = cmd_code;
                c.txd  = cmd_txd;
                c.nack = cmd_nack;
                obs_q.push_back(c);
                if (cmd_code == C_READ) begin
                    n_read_obs++;
                    chk("read_while_full", 32'(full_at_edge), 32'd0);
                end
                if (resp_q.size() != 0) r = resp_q.pop_front();
                else begin
                    r.ack = 1'b0;
                    r.rxd = 8'h00;
                    r.arb = 1'b0;
                end
                d = $urandom_range(min_dly, min_dly + 3);
                repeat (d) begin
                    @(negedge clk);
                    chk("cmd_held", {cmd_valid, cmd_code}, {1'b1, c.code});
                end
                cmd_done   = 1'b1;
                arb_lost   = r.arb;
                cmd_rx_ack = r.ack;
                cmd_rxd    = r.rxd;
                @(negedge clk);
                cmd_done   = 1'b0;
                arb_lost   = 1'b0;
                cmd_rx_ack = 1'b0;
                if (r.arb) begin
                    chk("valid_after_arb", 32'(cmd_valid), 32'd0);
                    chk("busy_after_arb", 32'(busy), 32'd0);
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: RX pushes, error pulses and the command scoreboard.
    initial begin
        cmd_t o;
        cmd_t e;
        forever begin
            @(negedge clk);
            if (nack_err) cnt_nack++;
            if (arb_err) cnt_arb++;
            if (seq_err) cnt_seq++;
            if (rx_wr) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'h0, rx_din}, 32'hFFFF_FFFF);
                else chk("rx_data", {24'h0, rx_din}, {24'h0, exp_rx.pop_front()});
            end
            #1;
            while (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    chk("cmd_unexpected", {29'h0, o.code}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_code", {29'h0, o.code}, {29'h0, e.code});
                    if (e.code == C_WRITE) chk("cmd_txd", {24'h0, o.txd}, {24'h0, e.txd});
                    if (e.code == C_READ) chk("cmd_nack", 32'(o.nack), 32'(e.nack));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  s_nack;
        int  s_arb;
        int  s_seq;
        int  n;
        int  k;
        bit  s;
        bit  ok;
        logic [7:0] a;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {5'h0, tx_rd, rx_wr, rx_din, cmd_valid, cmd_code, cmd_txd, cmd_nack,
             busy, nack_err, arb_err, seq_err}, 32'h0);
        step();
        rstn = 1'b1;
        cr_en = 1'b1;
        step();
        chk("post_reset_idle", {busy, cmd_valid, cmd_code}, 5'h0);

        // Plain write with STOP on the data byte.
        txq.push_back(10'h1A0);
        txq.push_back(10'h255);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        run_until_idle(300, 1'b0, 1'b0);

        // Read of three bytes, last NACKed.
        txq.push_back(10'h1A1);
        txq.push_back(10'h203);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_READ, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0);
        expect_cmd(C_READ, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0);
        expect_cmd(C_READ, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0);
        expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        run_until_idle(300, 1'b0, 1'b0);

        // Repeated start: write then read without an intervening STOP.
        txq.push_back(10'h1A0);
        txq.push_back(10'h010);
        txq.push_back(10'h1A1);
        txq.push_back(10'h201);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_READ, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0);
        expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        run_until_idle(300, 1'b0, 1'b0);

        // Address NACK: STOP follows and the data entry is left in the FIFO.
        s_nack = cnt_nack;
        min_dly = 3;
        txq.push_back(10'h1A0);
        txq.push_back(10'h255);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA0, 1'b0, 1'b1, 8'h00, 1'b0);
        expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (exp_q.size() == 0) cr_en = 1'b0;
            if (!cr_en && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("nack_idle", 32'(ok), 32'd1);
        chk("nack_pulses", cnt_nack - s_nack, 1);
        chk("nack_fifo_left", txq.size(), 1);
        if (txq.size() != 0) chk("nack_fifo_head", {22'h0, txq[0]}, 32'h255);
        txq.delete();
        step();
        step();
        cr_en = 1'b1;
        min_dly = 0;

        // Arbitration lost on a data WRITE, with a coincident done.
        s_arb = cnt_arb;
        s_seq = cnt_seq;
        txq.push_back(10'h1A0);
        txq.push_back(10'h055);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1);
        run_until_idle(300, 1'b0, 1'b0);
        repeat (5) step();
        chk("arb_pulses", cnt_arb - s_arb, 1);
        chk("arb_no_seq_err", cnt_seq - s_seq, 0);

        // RX FIFO full blocks READ issue until it clears.
        rx_full = 1'b1;
        n_read_obs = 0;
        txq.push_back(10'h1A1);
        txq.push_back(10'h202);
        expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_WRITE, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_cmd(C_READ, 8'h00, 1'b0, 1'b0, 8'hC3, 1'b0);
        expect_cmd(C_READ, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);
        expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (30) step();
        chk("no_read_while_full", n_read_obs, 0);
        chk("busy_while_full", 32'(busy), 32'd1);
        rx_full = 1'b0;
        run_until_idle(300, 1'b0, 1'b0);

        // Data entry with no START while idle.
        s_seq = cnt_seq;
        txq.push_back(10'h055);
        repeat (10) step();
        chk("seq_err_pulses", cnt_seq - s_seq, 1);
        chk("seq_err_popped", txq.size(), 0);
        chk("seq_err_idle", {busy, cmd_valid}, 2'b00);

        // Randomized transfer groups; a group without a final STOP is closed by cr_en=0.
        s_nack = cnt_nack;
        s_arb  = cnt_arb;
        s_seq  = cnt_seq;
        for (int g = 0; g < 14; g++) begin
            k = $urandom_range(1, 3);
            s = 1'b0;
            for (int j = 0; j < k; j++) begin
                d = 8'($urandom());
                a = d;
                n = $urandom_range(0, 4);
                s = ($urandom_range(0, 1) == 1);
                add_xfer(a, n, s);
            end
            if (!s) expect_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            run_until_idle(3000, !s, 1'b1);
        end
        chk("rand_err_pulses", (cnt_nack - s_nack) + (cnt_arb - s_arb) + (cnt_seq - s_seq), 0);
        chk("rand_rx_left", exp_rx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
